// File: rtl/keycode_pio_pkg.sv
// Register map and bit positions for the keycode FIFO PIO slave.
package keycode_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA   = 2'd0,
    ADDR_STATUS = 2'd1,
    ADDR_CTRL   = 2'd2,
    ADDR_RSVD   = 2'd3
  } reg_addr_e;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_IRQ       = 3;
  localparam int STAT_COUNT_LSB = 8;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 31;

endpackage

// File: rtl/keycode_fifo_pio_sync_fifo.sv
// Synchronous FIFO with occupancy count; flush clears pointers and overrides push/pop.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/keycode_fifo_pio.sv
// Avalon-MM keycode queue: Nios II pushes keycodes, fabric drains them over valid/ready.
module keycode_fifo_pio
  import keycode_pio_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int LOW_WATER = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              enable_q, enable_d;
  logic              irq_en_q, irq_en_d;
  logic              overflow_q, overflow_d;
  logic              irq_q, irq_d;
  logic              wr_data, wr_status, wr_ctrl;
  logic              flush, push, pop;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              unused_bus;

  assign wr_data   = chipselect & ~write_n & (address == ADDR_DATA);
  assign wr_status = chipselect & ~write_n & (address == ADDR_STATUS);
  assign wr_ctrl   = chipselect & ~write_n & (address == ADDR_CTRL);
  assign flush     = wr_ctrl & writedata[CTRL_FLUSH];
  assign push      = wr_data & ~fifo_full & ~flush;
  assign pop       = out_valid & out_ready;
  assign out_valid = enable_q & ~fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_head;
  assign irq       = irq_q;
  assign unused_bus = ^{read_n, writedata};

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (writedata[DATA_W-1:0]),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // irq is registered from the current count, so it trails a count change by one cycle.
  always_comb begin
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    overflow_d = overflow_q;
    if (wr_ctrl) begin
      enable_d = writedata[CTRL_ENABLE];
      irq_en_d = writedata[CTRL_IRQ_EN];
    end
    if (wr_status && writedata[STAT_OVF]) overflow_d = 1'b0;
    if (wr_data && fifo_full) overflow_d = 1'b1;
    irq_d = irq_en_q & enable_q & (32'(fifo_count) <= 32'(LOW_WATER));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  // For DEPTH=256 the count field spills into bit 16.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = 32'(out_data);
      ADDR_STATUS: begin
        readdata[STAT_EMPTY]               = fifo_empty;
        readdata[STAT_FULL]                = fifo_full;
        readdata[STAT_OVF]                 = overflow_q;
        readdata[STAT_IRQ]                 = irq_q;
        readdata[STAT_COUNT_LSB +: CW]     = fifo_count;
      end
      ADDR_CTRL: begin
        readdata[CTRL_ENABLE] = enable_q;
        readdata[CTRL_IRQ_EN] = irq_en_q;
      end
      default: readdata = '0;
    endcase
  end

endmodule
